// File: rtl/pulp_cluster_package.sv
// Cluster-wide constants shared by cluster blocks, including the defaults
// for the SoC event transmitter (event ID width and event queue depth).
package pulp_cluster_package;

  localparam int unsigned NB_CORES           = 8;
  localparam int unsigned NB_SOC_EVT_SRC     = 8;
  localparam int unsigned DEF_EVNT_WIDTH     = 8;
  localparam int unsigned DEF_EVT_FIFO_DEPTH = 4;

endpackage

// File: rtl/soc_evt_tx_if.sv
// Event handshake toward the cluster event unit.
//   evt_valid_o : event available (driven by the transmitter)
//   evt_ready_i : event accepted  (driven by the receiver)
//   evt_data_o  : event ID        (driven by the transmitter)
interface soc_evt_tx_if
  import pulp_cluster_package::*;
#(
  parameter int unsigned EVNT_WIDTH = DEF_EVNT_WIDTH
) ();

  logic                  evt_valid_o;
  logic                  evt_ready_i;
  logic [EVNT_WIDTH-1:0] evt_data_o;

  modport master (output evt_valid_o, output evt_data_o, input  evt_ready_i);
  modport slave  (input  evt_valid_o, input  evt_data_o, output evt_ready_i);

endinterface

// File: rtl/soc_evt_fifo.sv
// Event ID queue with registered count and full/empty flags.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : write request (ignored when full)
//   pop_i         : read request (ignored when empty)
//   data_o        : head entry, forced to zero when empty
//   full_o/empty_o: flags decoded from the registered count
module soc_evt_fifo
  import pulp_cluster_package::*;
#(
  parameter int unsigned WIDTH = DEF_EVNT_WIDTH,
  parameter int unsigned DEPTH = DEF_EVT_FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/soc_evt_tx.sv
// Collects SoC event pulses into per-source pending bits, arbitrates them
// round-robin into an ID queue and presents the queue to the cluster.
//   clk_i, rst_ni   : clock, async active-low reset
//   evt_i           : per-source event lines, one event per high cycle
//   evt_bus         : valid/ready/data handshake toward the event unit
//   evt_lost_o      : sticky per-source lost-event flags
//   evt_lost_clr_i  : per-bit clear of evt_lost_o (a new loss wins)
//   busy_o          : any pending bit set or queue non-empty
module soc_evt_tx
  import pulp_cluster_package::*;
#(
  parameter int unsigned NB_EVT_SRC = NB_SOC_EVT_SRC,
  parameter int unsigned EVNT_WIDTH = DEF_EVNT_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_EVT_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_EVT_SRC-1:0] evt_i,
  soc_evt_tx_if.master          evt_bus,
  output logic [NB_EVT_SRC-1:0] evt_lost_o,
  input  logic [NB_EVT_SRC-1:0] evt_lost_clr_i,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = $clog2(NB_EVT_SRC);

  logic [NB_EVT_SRC-1:0] r_pending;
  logic [NB_EVT_SRC-1:0] r_lost;
  logic [IDX_W-1:0]      r_prio;

  logic                  w_full;
  logic                  w_empty;
  logic [EVNT_WIDTH-1:0] w_head;
  logic                  w_gnt_vld;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [NB_EVT_SRC-1:0] w_gnt_oh;
  logic [IDX_W-1:0]      w_prio_nxt;
  int unsigned           w_scan;

  // Round-robin scan starting at r_prio; no grant while the queue is full.
  always_comb begin : arb
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    if (!w_full) begin
      for (int unsigned k = 0; k < NB_EVT_SRC; k++) begin
        w_scan = 32'(r_prio) + k;
        if (w_scan >= NB_EVT_SRC) w_scan = w_scan - NB_EVT_SRC;
        if (!w_gnt_vld && r_pending[w_scan[IDX_W-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_scan[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin : gnt_decode
    w_gnt_oh = '0;
    if (w_gnt_vld) w_gnt_oh[w_gnt_idx] = 1'b1;
    w_prio_nxt = (w_gnt_idx == IDX_W'(NB_EVT_SRC - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
  end

  // A pulse on a pending, non-granted source is dropped and flagged;
  // a pulse on the granted source re-arms its pending bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
      r_lost    <= '0;
      r_prio    <= '0;
    end else begin
      r_pending <= evt_i | (r_pending & ~w_gnt_oh);
      r_lost    <= (r_lost & ~evt_lost_clr_i) | (evt_i & r_pending & ~w_gnt_oh);
      if (w_gnt_vld) r_prio <= w_prio_nxt;
    end
  end

  soc_evt_fifo #(
    .WIDTH (EVNT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_gnt_vld),
    .data_i  (EVNT_WIDTH'(w_gnt_idx)),
    .pop_i   (evt_bus.evt_ready_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign evt_bus.evt_valid_o = ~w_empty;
  assign evt_bus.evt_data_o  = w_head;
  assign evt_lost_o          = r_lost;
  assign busy_o              = (|r_pending) | ~w_empty;

endmodule

// File: tb/tb_soc_evt_tx.sv
// Bench for soc_evt_tx: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_soc_evt_tx;

  localparam int NB = 8;
  localparam int EW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] evt;
  logic [NB-1:0] clr;
  logic [NB-1:0] lost;
  logic          busy;

  soc_evt_tx_if #(.EVNT_WIDTH(EW)) bus ();

  soc_evt_tx #(
    .NB_EVT_SRC (NB),
    .EVNT_WIDTH (EW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .evt_i          (evt),
    .evt_bus        (bus),
    .evt_lost_o     (lost),
    .evt_lost_clr_i (clr),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, ID queue, next-priority index.
  int        m_q[$];
  bit [NB-1:0] m_pend = '0;
  bit [NB-1:0] m_lost = '0;
  int        m_prio = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_pend = '0;
      m_lost = '0;
      m_prio = 0;
    end else begin
      int g;
      g = -1;
      if (m_q.size() < FD)
        for (int k = 0; k < NB; k++)
          if (g < 0 && m_pend[(m_prio + k) % NB]) g = (m_prio + k) % NB;
      if (m_q.size() > 0 && bus.evt_ready_i) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back(g);
        m_pend[g] = 1'b0;
        m_prio = (g + 1) % NB;
      end
      m_lost = m_lost & ~clr;
      for (int s = 0; s < NB; s++)
        if (evt[s]) begin
          if (m_pend[s]) m_lost[s] = 1'b1;
          m_pend[s] = 1'b1;
        end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      int ev, ed, eb;
      ev = (m_q.size() > 0) ? 1 : 0;
      ed = ev ? m_q[0] : 0;
      eb = (m_pend != 0 || ev) ? 1 : 0;
      total++;
      if (int'(bus.evt_valid_o) != ev || int'(bus.evt_data_o) != ed ||
          lost != m_lost || int'(busy) != eb) begin
        bad++;
        $display("FAIL model: got v=%0d d=%0d l=%h b=%0d expected v=%0d d=%0d l=%h b=%0d at %0t",
                 bus.evt_valid_o, bus.evt_data_o, lost, busy, ev, ed, m_lost, eb, $time);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    evt   = '0;
    clr   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.evt_ready_i = 1'b1;
    evt = '0;
    clr = '0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", int'(busy), 0);
  endtask

  initial begin
    int got[$];
    int cnt;
    evt = '0;
    clr = '0;
    bus.evt_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(bus.evt_valid_o), 0);
    chk("rst_data",  int'(bus.evt_data_o), 0);
    chk("rst_lost",  int'(lost), 0);
    chk("rst_busy",  int'(busy), 0);
    rst_n = 1'b1;

    // Single pulse on source 3: valid two cycles later for one cycle.
    @(negedge clk); evt = 8'h08;
    @(negedge clk); evt = 8'h00;
    chk("lat_t1_valid", int'(bus.evt_valid_o), 0);
    chk("lat_t1_busy",  int'(busy), 1);
    @(negedge clk);
    chk("lat_t2_valid", int'(bus.evt_valid_o), 1);
    chk("lat_t2_data",  int'(bus.evt_data_o), 3);
    @(negedge clk);
    chk("lat_t3_valid", int'(bus.evt_valid_o), 0);
    chk("lat_t3_busy",  int'(busy), 0);

    // All sources at once: IDs 0..7 back to back.
    do_reset();
    @(negedge clk); evt = 8'hFF;
    @(negedge clk); evt = 8'h00;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      chk($sformatf("burst_valid%0d", k), int'(bus.evt_valid_o), 1);
      chk($sformatf("burst_data%0d", k),  int'(bus.evt_data_o), k);
    end
    chk("burst_lost", int'(lost), 0);
    drain();

    // Stalled receiver: queue fills with 0..3, 4 and 5 stay pending.
    do_reset();
    bus.evt_ready_i = 1'b0;
    @(negedge clk); evt = 8'h3F;
    @(negedge clk); evt = 8'h00;
    repeat (4) @(negedge clk);
    chk("stall_valid", int'(bus.evt_valid_o), 1);
    chk("stall_data",  int'(bus.evt_data_o), 0);
    repeat (3) @(negedge clk);
    chk("stall_hold_valid", int'(bus.evt_valid_o), 1);
    chk("stall_hold_data",  int'(bus.evt_data_o), 0);
    bus.evt_ready_i = 1'b1;
    got.delete();
    for (int c = 0; c < 30; c++) begin
      if (bus.evt_valid_o && bus.evt_ready_i) got.push_back(int'(bus.evt_data_o));
      @(negedge clk);
    end
    chk("stall_count", got.size(), 6);
    for (int k = 0; k < 6; k++) begin
      int v;
      v = (k < got.size()) ? got[k] : -1;
      chk($sformatf("stall_order%0d", k), v, k);
    end
    chk("stall_lost", int'(lost), 0);

    // Loss on source 5 while queue full; set beats a simultaneous clear.
    do_reset();
    bus.evt_ready_i = 1'b0;
    @(negedge clk); evt = 8'h0F;
    @(negedge clk); evt = 8'h00;
    repeat (4) @(negedge clk);
    evt = 8'h20;
    @(negedge clk);
    @(negedge clk); evt = 8'h00;
    chk("lost_set", int'(lost), 32'h20);
    evt = 8'h20;
    clr = 8'h20;
    @(negedge clk);
    evt = 8'h00;
    chk("lost_set_wins", int'(lost), 32'h20);
    clr = 8'h20;
    @(negedge clk);
    clr = 8'h00;
    chk("lost_clear", int'(lost), 0);
    drain();

    // Re-pulse in the grant cycle: ID 2 delivered twice, nothing lost.
    do_reset();
    bus.evt_ready_i = 1'b1;
    @(negedge clk); evt = 8'h04;
    @(negedge clk); evt = 8'h04;
    @(negedge clk); evt = 8'h00;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.evt_valid_o && bus.evt_data_o == 8'd2) cnt++;
      @(negedge clk);
    end
    chk("regrant_count", cnt, 2);
    chk("regrant_lost", int'(lost), 0);

    // Reset with three queued events and a stalled receiver.
    do_reset();
    bus.evt_ready_i = 1'b0;
    @(negedge clk); evt = 8'h07;
    @(negedge clk); evt = 8'h00;
    repeat (3) @(negedge clk);
    chk("mid_valid", int'(bus.evt_valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.evt_valid_o), 0);
    chk("mid_rst_data",  int'(bus.evt_data_o), 0);
    chk("mid_rst_lost",  int'(lost), 0);
    chk("mid_rst_busy",  int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.evt_ready_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.evt_valid_o || busy) cnt++;
    end
    chk("post_rst_stale", cnt, 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      evt = NB'($urandom & $urandom & $urandom);
      if (c % 400 < 100) bus.evt_ready_i = ($urandom_range(0, 7) == 0);
      else               bus.evt_ready_i = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0) ? NB'($urandom) : '0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
